io_input_fifo: RTL and testbench

- Buffers words from an external input producer (switch bank / serial front end) and feeds them one at a time into the Memory block's memory-mapped input register at 0x0100.
- Sits directly upstream of Memory:
  - drives Memory.Input;
  - watches Memory.InputRecv;
  - pulses Memory.InputRst once the CPU has read the presented word.
- Prevents input loss when the producer is faster than the program polling 0x0100.

---
 rtl/io_pkg.sv | 18 +
 rtl/io_fifo_store.sv | 93 +++++++++
 rtl/io_input_fifo.sv | 141 ++++++++++++++
 tb/tb_io_input_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O blocks.
// Holds the I/O register addresses, the data word width and the
// state encoding of the input handshake FSM.
package io_pkg;

   localparam int          WORD_W      = 16;
   localparam logic [15:0] INPUT_ADDR  = 16'h0100;
   localparam logic [15:0] OUTPUT_ADDR = 16'h0000;

   // Input handshake states, in the order a word moves through them.
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PRESENT = 2'd1,
      ARMED   = 2'd2,
      CLEAR   = 2'd3
   } io_state_e;

endpackage

// File: rtl/io_fifo_store.sv
// Circular word buffer behind io_input_fifo.
// Holds the storage array, read/write pointers and the fill count.
// o_head is the oldest word; o_head_next is the word that becomes the head
// after a pop this cycle (bypassing i_data when only the head is stored).
// Build option IO_INPUT_FIFO_DROP_OLDEST_EN: a push while full and not
// popping discards the entry just behind the head and keeps the head.
module io_fifo_store
   import io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WORD_W-1:0]        i_data,
   output logic [WORD_W-1:0]        o_head,
   output logic [WORD_W-1:0]        o_head_next,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_en;
   logic              w_rd_en;
   logic              w_drop;

   // Pointer increment with explicit wrap from DEPTH-1 back to 0.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A pop frees a slot in the same cycle, so a full buffer may still accept.
   assign w_wr_en = i_push && (!w_full || i_pop);
   assign w_rd_en = i_pop && !w_empty;

`ifdef IO_INPUT_FIFO_DROP_OLDEST_EN
   // A single-entry buffer only holds the head, so the incoming word is lost.
   assign w_drop = i_push && w_full && !i_pop && (DEPTH > 1);
`else
   assign w_drop = 1'b0;
`endif

   // Pointer and count update; a drop advances both pointers, count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         if (w_wr_en || w_drop) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd_en || w_drop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write; on a drop the head is copied forward over the dropped
   // slot and the new word lands in the head's old slot (the write pointer).
   // NOTE: the array has no reset; pointers and count decide which words are valid.
   always_ff @(posedge clk) begin
      if (w_drop) begin
         r_mem[ptr_inc(r_rd_ptr)] <= r_mem[r_rd_ptr];
         r_mem[r_wr_ptr]          <= i_data;
      end else if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head      = r_mem[r_rd_ptr];
   assign o_head_next = (r_count > CW'(1)) ? r_mem[ptr_inc(r_rd_ptr)] : i_data;
   assign o_count     = r_count;
   assign o_full      = w_full;
   assign o_empty     = w_empty;

endmodule

// File: rtl/io_input_fifo.sv
// Input FIFO in front of the Memory block's input register.
// Buffers producer words and presents them one at a time on MemInput,
// waits for Memory to flag the word (InputRecv) and the CPU to read the
// input address, then pulses InputRst for one cycle and advances.
// Build option IO_INPUT_FIFO_DROP_OLDEST_EN: InReady stays high after reset
// and a push into a full FIFO drops the oldest word not yet presented.
module io_input_fifo #(
   parameter int          DEPTH      = 4,
   parameter logic [15:0] INPUT_ADDR = io_pkg::INPUT_ADDR
) (
   input  logic                        Clk,
   input  logic                        Rst_n,
   input  logic [io_pkg::WORD_W-1:0]   InData,
   input  logic                        InValid,
   output logic                        InReady,
   input  logic [15:0]                 Addr,
   input  logic                        WriteFlag,
   input  logic                        InputRecv,
   output logic [io_pkg::WORD_W-1:0]   MemInput,
   output logic                        InputRst,
   output logic [$clog2(DEPTH):0]      Count,
   output logic                        Overflow
);

   import io_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   io_state_e         r_state;
   io_state_e         w_state_next;
   logic              r_run;
   logic [WORD_W-1:0] r_mem_input;
   logic              r_overflow;

   logic              w_push;
   logic              w_pop;
   logic              w_ready;
   logic              w_lost;
   logic              w_full;
   logic              w_empty;
   logic              w_cpu_read;
   logic              w_load;
   logic [WORD_W-1:0] w_load_data;
   logic [WORD_W-1:0] w_head;
   logic [WORD_W-1:0] w_head_next;
   logic [CW-1:0]     w_count;

   // The head leaves the buffer during the single CLEAR cycle.
   assign w_pop = (r_state == CLEAR);

`ifdef IO_INPUT_FIFO_DROP_OLDEST_EN
   assign w_ready = r_run;
`else
   assign w_ready = r_run && (!w_full || w_pop);
`endif

   assign w_push     = InValid && w_ready;
   assign w_lost     = InValid && w_full && !w_pop;
   assign w_cpu_read = (Addr == INPUT_ADDR) && !WriteFlag;

   io_fifo_store #(
      .DEPTH (DEPTH)
   ) u_store (
      .clk         (Clk),
      .rst_n       (Rst_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_data      (InData),
      .o_head      (w_head),
      .o_head_next (w_head_next),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // Holds InReady low until the first edge after reset release.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_run <= 1'b0;
      else        r_run <= 1'b1;
   end

   // Handshake state register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= EMPTY;
      else        r_state <= w_state_next;
   end

   // Next-state and MemInput load decisions.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_data  = w_head;
      case (r_state)
         EMPTY: begin
            if (!w_empty) begin
               w_load       = 1'b1;
               w_load_data  = w_head;
               // A flag still set from an earlier word skips straight ahead.
               w_state_next = InputRecv ? ARMED : PRESENT;
            end
         end
         PRESENT: begin
            if (InputRecv) w_state_next = ARMED;
         end
         ARMED: begin
            if (w_cpu_read) w_state_next = CLEAR;
         end
         CLEAR: begin
            // Anything left after this pop (or arriving now) is presented at once.
            if ((w_count != CW'(1)) || w_push) begin
               w_load       = 1'b1;
               w_load_data  = w_head_next;
               w_state_next = PRESENT;
            end else begin
               w_state_next = EMPTY;
            end
         end
         default: w_state_next = EMPTY;
      endcase
   end

   // Presented word; only changes when a word enters presentation.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)      r_mem_input <= '0;
      else if (w_load) r_mem_input <= w_load_data;
   end

   // Sticky loss flag, cleared only by reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)      r_overflow <= 1'b0;
      else if (w_lost) r_overflow <= 1'b1;
   end

   assign InReady  = w_ready;
   assign MemInput = r_mem_input;
   assign InputRst = (r_state == CLEAR);
   assign Count    = w_count;
   assign Overflow = r_overflow;

endmodule

// File: tb/tb_io_input_fifo.sv
// Directed bench for io_input_fifo (DEPTH=4).
// Stimulus pushes the words it expects to see presented into a queue; a
// monitor compares MemInput against the queue head on every InputRst pulse.
module tb_io_input_fifo;

   localparam logic [15:0] IN_ADDR = 16'h0100;

   logic        Clk;
   logic        Rst_n;
   logic [15:0] InData;
   logic        InValid;
   logic        InReady;
   logic [15:0] Addr;
   logic        WriteFlag;
   logic        InputRecv;
   logic [15:0] MemInput;
   logic        InputRst;
   logic [2:0]  Count;
   logic        Overflow;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q[$];

   io_input_fifo #(
      .DEPTH      (4),
      .INPUT_ADDR (16'h0100)
   ) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .InData    (InData),
      .InValid   (InValid),
      .InReady   (InReady),
      .Addr      (Addr),
      .WriteFlag (WriteFlag),
      .InputRecv (InputRecv),
      .MemInput  (MemInput),
      .InputRst  (InputRst),
      .Count     (Count),
      .Overflow  (Overflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one word for one edge; caller drops InValid afterwards.
   task automatic send(input logic [15:0] d, input logic exp_rdy, input string tag);
      check({tag, "_in_ready"}, {31'd0, InReady}, {31'd0, exp_rdy});
      InData  = d;
      InValid = 1'b1;
      @(negedge Clk);
   endtask

   // Flag the word as received, issue one CPU read, expect one InputRst pulse.
   task automatic consume(input string tag);
      int n;
      n = 0;
      InputRecv = 1'b1;
      @(negedge Clk);
      Addr      = IN_ADDR;
      WriteFlag = 1'b0;
      do begin
         @(negedge Clk);
         n++;
      end while (!InputRst && n < 8);
      check({tag, "_pulse"}, {31'd0, InputRst}, 32'd1);
      Addr      = 16'h0000;
      InputRecv = 1'b0;
      @(negedge Clk);
      check({tag, "_single"}, {31'd0, InputRst}, 32'd0);
   endtask

   // Scoreboard monitor: every pulse consumes the word on MemInput.
   always @(negedge Clk) begin
      logic [15:0] w;
      if (Rst_n && InputRst) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got MemInput %h expected no pulse", MemInput);
         end else begin
            w = exp_q.pop_front();
            check("sb_word", {16'd0, MemInput}, {16'd0, w});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      Rst_n     = 1'b0;
      InData    = 16'h0000;
      InValid   = 1'b0;
      Addr      = 16'h0000;
      WriteFlag = 1'b0;
      InputRecv = 1'b0;

      // Reset state
      @(negedge Clk);
      check("rst_count",     {29'd0, Count},    32'd0);
      check("rst_meminput",  {16'd0, MemInput}, 32'h0);
      check("rst_inputrst",  {31'd0, InputRst}, 32'd0);
      check("rst_overflow",  {31'd0, Overflow}, 32'd0);
      check("rst_in_ready",  {31'd0, InReady},  32'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      check("rel_in_ready",  {31'd0, InReady},  32'd1);

      // 1: single word BEEF
      send(16'hBEEF, 1'b1, "t1");
      InValid = 1'b0;
      exp_q.push_back(16'hBEEF);
      check("t1_count_push", {29'd0, Count},    32'd1);
      check("t1_not_yet",    {16'd0, MemInput}, 32'h0);
      @(negedge Clk);
      check("t1_presented",  {16'd0, MemInput}, 32'hBEEF);
      consume("t1");
      check("t1_count_pop",  {29'd0, Count},    32'd0);
      check("t1_mem_hold",   {16'd0, MemInput}, 32'hBEEF);

      // 2: fill to DEPTH, then a fifth word with no pop
      send(16'h0001, 1'b1, "t2a");
      send(16'h0002, 1'b1, "t2b");
      send(16'h0003, 1'b1, "t2c");
      send(16'h0004, 1'b1, "t2d");
      InValid = 1'b0;
      check("t2_count_full", {29'd0, Count},    32'd4);
      check("t2_ovf_before", {31'd0, Overflow}, 32'd0);
`ifdef IO_INPUT_FIFO_DROP_OLDEST_EN
      // Head 0001 is presented; 0002 is dropped in favour of 0005.
      send(16'h0005, 1'b1, "t2e");
      InValid = 1'b0;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0003);
      exp_q.push_back(16'h0004);
      exp_q.push_back(16'h0005);
      check("t2_ready_drop", {31'd0, InReady},  32'd1);
`else
      send(16'h0005, 1'b0, "t2e");
      InValid = 1'b0;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0002);
      exp_q.push_back(16'h0003);
      exp_q.push_back(16'h0004);
      check("t2_ready_full", {31'd0, InReady},  32'd0);
`endif
      check("t2_overflow",   {31'd0, Overflow}, 32'd1);
      check("t2_count_keep", {29'd0, Count},    32'd4);
      for (int i = 0; i < 4; i++) begin
         consume("t2");
         check("t2_count_drain", {29'd0, Count}, 32'(3 - i));
      end
      check("t2_ready_empty", {31'd0, InReady}, 32'd1);

      // 3: a CPU write to the input address is not a read
      send(16'h0055, 1'b1, "t3");
      InValid = 1'b0;
      exp_q.push_back(16'h0055);
      @(negedge Clk);
      InputRecv = 1'b1;
      @(negedge Clk);
      Addr      = IN_ADDR;
      WriteFlag = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("t3_no_pulse", {31'd0, InputRst}, 32'd0);
         check("t3_no_pop",   {29'd0, Count},    32'd1);
         check("t3_mem_same", {16'd0, MemInput}, 32'h0055);
      end
      WriteFlag = 1'b0;
      Addr      = 16'h0000;
      consume("t3");

      // 5: reset while ARMED with three words stored
      send(16'h0071, 1'b1, "t5a");
      send(16'h0072, 1'b1, "t5b");
      send(16'h0073, 1'b1, "t5c");
      InValid   = 1'b0;
      InputRecv = 1'b1;
      @(negedge Clk);
      check("t5_count_pre", {29'd0, Count}, 32'd3);
      #2 Rst_n = 1'b0;
      #1;
      check("t5_rst_count",    {29'd0, Count},    32'd0);
      check("t5_rst_meminput", {16'd0, MemInput}, 32'h0);
      check("t5_rst_inputrst", {31'd0, InputRst}, 32'd0);
      check("t5_rst_overflow", {31'd0, Overflow}, 32'd0);
      check("t5_rst_ready",    {31'd0, InReady},  32'd0);
      InputRecv = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      send(16'h1234, 1'b1, "t5d");
      InValid = 1'b0;
      exp_q.push_back(16'h1234);
      @(negedge Clk);
      check("t5_presented", {16'd0, MemInput}, 32'h1234);
      consume("t5");

      // 4: push into a full FIFO during the CLEAR pop
      send(16'h0011, 1'b1, "t4a");
      send(16'h0022, 1'b1, "t4b");
      send(16'h0033, 1'b1, "t4c");
      send(16'h0044, 1'b1, "t4d");
      InValid = 1'b0;
      exp_q.push_back(16'h0011);
      exp_q.push_back(16'h0022);
      exp_q.push_back(16'h0033);
      exp_q.push_back(16'h0044);
      @(negedge Clk);
      InputRecv = 1'b1;
      @(negedge Clk);
      Addr = IN_ADDR;
      @(negedge Clk);
      check("t4_pulse",       {31'd0, InputRst}, 32'd1);
      check("t4_ready_clear", {31'd0, InReady},  32'd1);
      Addr      = 16'h0000;
      InputRecv = 1'b0;
      InData    = 16'hCAFE;
      InValid   = 1'b1;
      exp_q.push_back(16'hCAFE);
      @(negedge Clk);
      InValid = 1'b0;
      check("t4_count_same", {29'd0, Count},    32'd4);
      check("t4_overflow",   {31'd0, Overflow}, 32'd0);
      check("t4_next_head",  {16'd0, MemInput}, 32'h0022);
      for (int i = 0; i < 4; i++) consume("t4");
      check("t4_count_end",  {29'd0, Count},    32'd0);

      check("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
